shift_reg_unit: RTL

- Datapath-side responder to the control unit's shift command interface (`shift_control` / `shift_src_control` / `shift_amount_control` path).
- Holds a 32-bit operand and a 5-bit shift amount. Executes the commanded shift or rotate serially, one bit per cycle.
- Reports `busy`/`done` so the control FSM can wait on the result.
- Its output feeds the register-file write-back mux (`mem_to_reg` = 3'b101 path).

---
 rtl/shift_pkg.sv | 31 +++
 rtl/shift_one_step.sv | 31 +++
 rtl/shift_reg_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift unit and the control unit that drives it:
//   - shift_cmd_e   : shift_control command encodings (same values the control
//                     unit drives on shift_control)
//   - shift_state_e : shift unit FSM state encodings
//   - DATA_W_DEF / AMT_W_DEF : default operand and shift-amount widths
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int AMT_W_DEF  = 5;

    typedef enum logic [2:0] {
        DO_NOTHING = 3'b000,
        LOAD_SRC   = 3'b001,
        LEFT_ARTH  = 3'b010,
        RIGHT_LOG  = 3'b011,
        RIGHT_ART  = 3'b100,
        ROTATE_RT  = 3'b101,
        ROTATE_LT  = 3'b110,
        CMD_RSVD   = 3'b111
    } shift_cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_one_step.sv
// -----------------------------------------------------------------------------
// shift_one_step
// Combinational single-bit shift/rotate used by the serial shift unit.
// Ports:
//   op : shift opcode (shift_cmd_e value); non-shift opcodes pass d through
//   d  : operand
//   q  : operand shifted/rotated by exactly one bit
// -----------------------------------------------------------------------------
module shift_one_step
    import shift_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            LEFT_ARTH: q = {d[DATA_W-2:0], 1'b0};
            RIGHT_LOG: q = {1'b0, d[DATA_W-1:1]};
            RIGHT_ART: q = {d[DATA_W-1], d[DATA_W-1:1]};
            ROTATE_RT: q = {d[0], d[DATA_W-1:1]};
            ROTATE_LT: q = {d[DATA_W-2:0], d[DATA_W-1]};
            default:   q = d;
        endcase
    end

endmodule

// File: rtl/shift_reg_unit.sv
// -----------------------------------------------------------------------------
// shift_reg_unit
// Datapath shift register answering the control unit's shift commands.
// An operand and shift amount are captured with LOAD_SRC; a shift/rotate
// command then runs serially, one bit per clock, and signals completion with
// a one-cycle done pulse while data_out holds the result.
//
// Build option: define SHIFT_REG_UNIT_BARREL_EN to replace the serial path
// with a single-cycle barrel shifter (busy then never asserts; results are
// identical to the serial build).
//
// Ports:
//   clock         : system clock, rising edge
//   reset         : synchronous reset, active low
//   shift_control : command (shift_cmd_e)
//   data_in       : operand, captured on LOAD_SRC
//   n_in          : shift amount, captured on LOAD_SRC
//   data_out      : operand register contents
//   busy          : high while a serial shift is in progress
//   done          : one-cycle pulse, data_out holds the final result
// -----------------------------------------------------------------------------
module shift_reg_unit
    import shift_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMT_W  = AMT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        shift_control,
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  n_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done
);

    shift_state_e      state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [AMT_W-1:0]  cnt_q,   cnt_d;
    logic [2:0]        op_q,    op_d;

`ifdef SHIFT_REG_UNIT_BARREL_EN
    // Full-amount shift in one step. Rotates use a doubled operand so an
    // amount of zero needs no special case.
    function automatic logic [DATA_W-1:0] barrel(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] d,
        input logic [AMT_W-1:0]  n
    );
        logic [2*DATA_W-1:0] dd;
        dd     = {d, d};
        barrel = d;
        case (op)
            LEFT_ARTH: barrel = d << n;
            RIGHT_LOG: barrel = d >> n;
            RIGHT_ART: barrel = $unsigned($signed(d) >>> n);
            ROTATE_RT: begin
                dd     = dd >> n;
                barrel = dd[DATA_W-1:0];
            end
            ROTATE_LT: begin
                dd     = dd << n;
                barrel = dd[2*DATA_W-1:DATA_W];
            end
            default:   barrel = d;
        endcase
    endfunction
`else
    logic [DATA_W-1:0] step_data;

    shift_one_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .op (op_q),
        .d  (data_q),
        .q  (step_data)
    );
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;

        case (state_q)
            IDLE, DONE: begin
                case (shift_control)
                    LOAD_SRC: begin
                        data_d  = data_in;
                        cnt_d   = n_in;
                        state_d = IDLE;
                    end
                    LEFT_ARTH, RIGHT_LOG, RIGHT_ART, ROTATE_RT, ROTATE_LT: begin
                        op_d = shift_control;
`ifdef SHIFT_REG_UNIT_BARREL_EN
                        data_d  = barrel(shift_control, data_q, cnt_q);
                        cnt_d   = '0;
                        state_d = DONE;
`else
                        // A consumed (zero) count completes at once, data untouched.
                        state_d = (cnt_q == '0) ? DONE : SHIFT;
`endif
                    end
                    default: state_d = IDLE;
                endcase
            end

            SHIFT: begin
                // shift_control is deliberately ignored while shifting.
`ifndef SHIFT_REG_UNIT_BARREL_EN
                data_d = step_data;
`endif
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= DO_NOTHING;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign data_out = data_q;
    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);

endmodule
